// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, ALU codes,
// opcode/function constants and datapath mux select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    typedef struct packed {
        logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
        logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne;
        logic i_lui, i_j, i_jal;
    } dec_t;

    // Address arithmetic (addi/lw/sw) falls through to add.
    function automatic logic [3:0] alu_code(input dec_t d);
        logic [3:0] c;
        c = ALU_ADD;
        if (d.i_sub | d.i_beq | d.i_bne) c = ALU_SUB;
        if (d.i_and | d.i_andi)          c = ALU_AND;
        if (d.i_or  | d.i_ori)           c = ALU_OR;
        if (d.i_xor | d.i_xori)          c = ALU_XOR;
        if (d.i_lui)                     c = ALU_LUI;
        if (d.i_sll)                     c = ALU_SLL;
        if (d.i_srl)                     c = ALU_SRL;
        if (d.i_sra)                     c = ALU_SRA;
        return c;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode into one-hot i_* flags plus R-type and
// unsupported-instruction summaries.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec,
    output logic       rtype,
    output logic       nop
);

    logic r;
    assign r = (op == OP_R);

    always_comb begin
        dec        = '0;
        dec.i_add  = r && (func == FN_ADD);
        dec.i_sub  = r && (func == FN_SUB);
        dec.i_and  = r && (func == FN_AND);
        dec.i_or   = r && (func == FN_OR);
        dec.i_xor  = r && (func == FN_XOR);
        dec.i_sll  = r && (func == FN_SLL);
        dec.i_srl  = r && (func == FN_SRL);
        dec.i_sra  = r && (func == FN_SRA);
        dec.i_jr   = r && (func == FN_JR);
        dec.i_addi = (op == OP_ADDI);
        dec.i_andi = (op == OP_ANDI);
        dec.i_ori  = (op == OP_ORI);
        dec.i_xori = (op == OP_XORI);
        dec.i_lw   = (op == OP_LW);
        dec.i_sw   = (op == OP_SW);
        dec.i_beq  = (op == OP_BEQ);
        dec.i_bne  = (op == OP_BNE);
        dec.i_lui  = (op == OP_LUI);
        dec.i_j    = (op == OP_J);
        dec.i_jal  = (op == OP_JAL);
    end

    assign rtype = dec.i_add | dec.i_sub | dec.i_and | dec.i_or | dec.i_xor |
                   dec.i_sll | dec.i_srl | dec.i_sra | dec.i_jr;
    assign nop   = ~|dec;

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB FSM driving the
// shared-memory datapath's mux selects and write strobes.
module mc_cu
    import mc_pkg::*;
#(
    parameter int ALUC_W = 4,
    parameter int MEM_HS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              z,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              iord,
    output logic              wir,
    output logic              wpc,
    output logic              wreg,
    output logic              wmem,
    output logic              regrt,
    output logic              m2reg,
    output logic              shift,
    output logic              sext,
    output logic              jal,
    output logic [1:0]        alusrcb,
    output logic              alusrca,
    output logic [ALUC_W-1:0] aluc,
    output logic [1:0]        pcsource,
    output logic [2:0]        state
);

    dec_t   dec;
    logic   rtype, nop, ready;
    state_t state_q, state_d;

    mc_decode u_dec (
        .op    (op),
        .func  (func),
        .dec   (dec),
        .rtype (rtype),
        .nop   (nop)
    );

    assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = ready ? S_ID : S_IF;
            S_ID:  state_d = (nop | dec.i_j | dec.i_jr | dec.i_jal) ? S_IF : S_EXE;
            S_EXE: begin
                if (dec.i_beq | dec.i_bne)    state_d = S_IF;
                else if (dec.i_lw | dec.i_sw) state_d = S_MEM;
                else                          state_d = S_WB;
            end
            S_MEM: begin
                if (!ready)        state_d = S_MEM;
                else if (dec.i_lw) state_d = S_WB;
                else               state_d = S_IF;
            end
            S_WB:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        wir      = 1'b0;
        wpc      = 1'b0;
        wreg     = 1'b0;
        wmem     = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        pcsource = PCS_ALU;
        aluc     = ALUC_W'(ALU_ADD);
        regrt    = ~rtype;
        m2reg    = dec.i_lw;
        sext     = ~(dec.i_andi | dec.i_ori | dec.i_xori);
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                wir     = ready;
                wpc     = ready;
            end
            S_ID: begin
                alusrcb = SRCB_BR;
                if (dec.i_j | dec.i_jal) begin
                    wpc      = 1'b1;
                    pcsource = PCS_J;
                    wreg     = dec.i_jal;
                    jal      = dec.i_jal;
                end else if (dec.i_jr) begin
                    wpc      = 1'b1;
                    pcsource = PCS_JR;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                alusrcb = (rtype | dec.i_beq | dec.i_bne) ? SRCB_REG : SRCB_IMM;
                aluc    = ALUC_W'(alu_code(dec));
                shift   = dec.i_sll | dec.i_srl | dec.i_sra;
                if (dec.i_beq | dec.i_bne) begin
                    wpc      = (dec.i_beq & z) | (dec.i_bne & ~z);
                    pcsource = PCS_BR;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = dec.i_sw & ready;
            end
            S_WB: wreg = 1'b1;
            default: ;
        endcase
        // Reset must silence the bus and strobes even though state reads IF.
        if (reset) begin
            mem_req = 1'b0;
            wir     = 1'b0;
            wpc     = 1'b0;
            wreg    = 1'b0;
            wmem    = 1'b0;
        end
    end

endmodule
